// File: rtl/hh_pkg.sv
// Shared types and constants for the HH rate-constant datapath and its scheduler.
package hh_pkg;

   localparam int unsigned RATE_W    = 16;
   localparam int unsigned NUM_RATES = 6;
   localparam int unsigned RATES_W   = RATE_W * NUM_RATES;

   // Bit offsets of each rate inside the packed {an,am,ah,bn,bm,bh} word
   localparam int unsigned AN_OFF = 5 * RATE_W;
   localparam int unsigned AM_OFF = 4 * RATE_W;
   localparam int unsigned AH_OFF = 3 * RATE_W;
   localparam int unsigned BN_OFF = 2 * RATE_W;
   localparam int unsigned BM_OFF = 1 * RATE_W;
   localparam int unsigned BH_OFF = 0;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } sched_state_t;

   // Rate unit is held in reset long enough for its whole pipeline to clear
   function automatic int unsigned flush_cycles(input int unsigned rate_lat);
      return rate_lat + 1;
   endfunction

endpackage

// File: rtl/hh_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request after ptr, wrapping at NUM_REQ.
module hh_rr_arbiter
   import hh_pkg::*;
#(
   parameter int unsigned  NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt_c,
   output logic [ID_W-1:0]    id_c,
   output logic               valid_c
);

   logic [ID_W-1:0] idx;

   // Walk ptr+1 .. ptr+NUM_REQ modulo NUM_REQ, keep the first hit
   always_comb begin
      gnt_c   = '0;
      id_c    = '0;
      valid_c = 1'b0;
      idx     = ptr;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
         if (!valid_c && req[idx]) begin
            valid_c    = 1'b1;
            id_c       = idx;
            gnt_c[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hh_rate_scheduler.sv
// Shares one HH rate unit among NUM_REQ requesters with tagged, in-order responses.
// Optional performance counters: define HH_SCHED_PERF_EN.
module hh_rate_scheduler
   import hh_pkg::*;
#(
   parameter int unsigned  NUM_REQ  = 4,
   parameter int unsigned  RATE_LAT = 2,
   localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_enable,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*RATE_W-1:0] req_voltage,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [RATE_W-1:0]         rate_voltage,
   output logic                      rate_rst_n,
   input  logic [RATES_W-1:0]        rate_in,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [RATES_W-1:0]        rsp_rates,
   output logic                      busy
`ifdef HH_SCHED_PERF_EN
   ,
   output logic [31:0]               perf_grants,
   output logic [31:0]               perf_stalls
`endif
);

   localparam int unsigned DEPTH   = RATE_LAT + 1;
   localparam int unsigned FLUSH_N = flush_cycles(RATE_LAT);
   localparam int unsigned CNT_W   = $clog2(FLUSH_N + 1);

   sched_state_t               state_q, state_d;
   logic [CNT_W-1:0]           fcnt_q, fcnt_d;
   logic [ID_W-1:0]            ptr_q, ptr_d;
   logic [DEPTH-1:0]           tag_v_q, tag_v_d;
   logic [DEPTH-1:0][ID_W-1:0] tag_id_q, tag_id_d;
   logic [RATE_W-1:0]          rate_voltage_q, rate_voltage_d;
   logic                       rate_rst_n_q, rate_rst_n_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
   logic [RATES_W-1:0]         rsp_rates_q, rsp_rates_d;
   logic                       busy_q, busy_d;

   logic [NUM_REQ-1:0]         arb_gnt;
   logic [ID_W-1:0]            arb_id;
   logic                       arb_valid;
   logic                       issue_c;

   hh_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt_c   (arb_gnt),
      .id_c    (arb_id),
      .valid_c (arb_valid)
   );

   // Grant is a same-cycle handshake so the requester can drop req on the next cycle
   assign issue_c = !rst && (state_q == RUN) && cfg_enable && arb_valid;
   assign gnt     = issue_c ? arb_gnt : '0;

   // Sequencer: flush, run, drain, halt; round-robin pointer follows each winner
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         FLUSH: begin
            if (fcnt_q == CNT_W'(FLUSH_N - 1)) begin
               fcnt_d  = '0;
               state_d = cfg_enable ? RUN : HALT;
            end else begin
               fcnt_d = fcnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!cfg_enable) state_d = DRAIN;
            else if (arb_valid) ptr_d = arb_id;
         end
         DRAIN: begin
            if (tag_v_q == '0) state_d = cfg_enable ? RUN : HALT;
         end
         HALT: begin
            if (cfg_enable) state_d = RUN;
         end
         default: state_d = FLUSH;
      endcase
   end

   // Issue path, tag pipeline aligned with the rate unit, and response capture
   always_comb begin
      tag_v_d        = '0;
      tag_id_d       = '0;
      tag_v_d[0]     = issue_c;
      tag_id_d[0]    = arb_id;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end
      rate_voltage_d = issue_c ? req_voltage[32'(arb_id) * RATE_W +: RATE_W] : rate_voltage_q;
      rate_rst_n_d   = (state_d != FLUSH);
      rsp_valid_d    = tag_v_q[DEPTH-1];
      rsp_id_d       = tag_v_q[DEPTH-1] ? tag_id_q[DEPTH-1] : rsp_id_q;
      rsp_rates_d    = tag_v_q[DEPTH-1] ? rate_in : rsp_rates_q;
      busy_d         = (|tag_v_d) || (state_d == FLUSH) || (state_d == DRAIN);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= FLUSH;
         fcnt_q         <= '0;
         ptr_q          <= ID_W'(NUM_REQ - 1);
         tag_v_q        <= '0;
         tag_id_q       <= '0;
         rate_voltage_q <= '0;
         rate_rst_n_q   <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_rates_q    <= '0;
         busy_q         <= 1'b1;
      end else begin
         state_q        <= state_d;
         fcnt_q         <= fcnt_d;
         ptr_q          <= ptr_d;
         tag_v_q        <= tag_v_d;
         tag_id_q       <= tag_id_d;
         rate_voltage_q <= rate_voltage_d;
         rate_rst_n_q   <= rate_rst_n_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_rates_q    <= rsp_rates_d;
         busy_q         <= busy_d;
      end
   end

   assign rate_voltage = rate_voltage_q;
   assign rate_rst_n   = rate_rst_n_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_rates    = rsp_rates_q;
   assign busy         = busy_q;

`ifdef HH_SCHED_PERF_EN
   logic [31:0] perf_grants_q, perf_grants_d;
   logic [31:0] perf_stalls_q, perf_stalls_d;
   logic        stall_c;

   assign stall_c = (state_q == RUN) && cfg_enable && (req != '0) && !arb_valid;

   // Saturating grant and stall counters
   always_comb begin
      perf_grants_d = perf_grants_q;
      perf_stalls_d = perf_stalls_q;
      if (issue_c && (perf_grants_q != '1)) perf_grants_d = perf_grants_q + 32'd1;
      if (stall_c && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grants_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_grants_q <= perf_grants_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign perf_grants = perf_grants_q;
   assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_hh_rate_scheduler.sv
// Directed bench for hh_rate_scheduler with a behavioural rate unit and response scoreboard.
module tb_hh_rate_scheduler;
   import hh_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned RLAT = 2;
   localparam int unsigned IDW  = 2;
   localparam int          LAT  = RLAT + 2;

   typedef struct {
      logic [IDW-1:0]     id;
      logic [RATES_W-1:0] rates;
      int                 due;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     cfg_enable;
   logic [NREQ-1:0]          req;
   logic [NREQ*RATE_W-1:0]   req_voltage;
   logic [NREQ-1:0]          gnt;
   logic [RATE_W-1:0]        rate_voltage;
   logic                     rate_rst_n;
   logic [RATES_W-1:0]       rate_in;
   logic                     rsp_valid;
   logic [IDW-1:0]           rsp_id;
   logic [RATES_W-1:0]       rsp_rates;
   logic                     busy;
`ifdef HH_SCHED_PERF_EN
   logic [31:0]              perf_grants;
   logic [31:0]              perf_stalls;
`endif

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   exp_t        sb[$];
   int          gnt_log[$];
   logic [NREQ-1:0] keep;
   logic [NREQ-1:0] last_gnt;
   logic [RATES_W-1:0] ru_s1;

   always #5 clk = ~clk;

   hh_rate_scheduler #(.NUM_REQ(NREQ), .RATE_LAT(RLAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_enable   (cfg_enable),
      .req          (req),
      .req_voltage  (req_voltage),
      .gnt          (gnt),
      .rate_voltage (rate_voltage),
      .rate_rst_n   (rate_rst_n),
      .rate_in      (rate_in),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_rates    (rsp_rates),
      .busy         (busy)
`ifdef HH_SCHED_PERF_EN
      ,
      .perf_grants  (perf_grants),
      .perf_stalls  (perf_stalls)
`endif
   );

   function automatic logic [RATES_W-1:0] rate_fn(input logic [RATE_W-1:0] v);
      return {v, ~v, v ^ 16'h5A5A, v + 16'd1, v + 16'd3, {v[7:0], v[15:8]}};
   endfunction

   // Behavioural rate unit: two registered stages from voltage to rates
   always @(posedge clk) begin
      if (rate_rst_n !== 1'b1) begin
         ru_s1   <= '0;
         rate_in <= '0;
      end else begin
         ru_s1   <= rate_fn(rate_voltage);
         rate_in <= ru_s1;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void set_v(input int i, input logic [RATE_W-1:0] v);
      req_voltage[i*RATE_W +: RATE_W] = v;
   endfunction

   // One clock: observe grants/responses mid-cycle, then advance past the edge
   task automatic cycle();
      logic [NREQ-1:0] drop;
      exp_t            e;
      drop = '0;
      #1;
      last_gnt = gnt;
      if (gnt != '0) begin
         check("gnt_onehot", 128'($onehot(gnt)), 128'(1));
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
               e.id    = IDW'(i);
               e.rates = rate_fn(req_voltage[i*RATE_W +: RATE_W]);
               e.due   = cyc + LAT;
               sb.push_back(e);
               gnt_log.push_back(i);
               if (!keep[i]) drop[i] = 1'b1;
            end
         end
      end
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 128'(rsp_valid), 128'(0));
         end else begin
            e = sb.pop_front();
            check("rsp_id", 128'(rsp_id), 128'(e.id));
            check("rsp_rates", 128'(rsp_rates), 128'(e.rates));
            check("rsp_latency", 128'(cyc), 128'(e.due));
         end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
         check("rsp_missing", 128'(rsp_valid), 128'(1));
         void'(sb.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      req = req & ~drop;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 12) begin
         cycle();
         n++;
      end
      check("drain_empty", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_enable = 1'b1; req = '0; req_voltage = '0; keep = '0;
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      check("rst_gnt", 128'(gnt), 128'(0));
      check("rst_rate_voltage", 128'(rate_voltage), 128'(0));
      check("rst_rate_rst_n", 128'(rate_rst_n), 128'(0));
      check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check("rst_rsp_id", 128'(rsp_id), 128'(0));
      check("rst_rsp_rates", 128'(rsp_rates), 128'(0));
      check("rst_busy", 128'(busy), 128'(1));

      // 1: flush holds rate unit in reset for exactly three cycles
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("flush_rate_rst_n", 128'(rate_rst_n), 128'(0));
         cycle();
         check("flush_gnt", 128'(last_gnt), 128'(0));
      end
      check("post_flush_rate_rst_n", 128'(rate_rst_n), 128'(1));
      check("post_flush_busy", 128'(busy), 128'(0));

      // 2: single request on requester 2
      set_v(2, 16'hF800);
      req = 4'b0100;
      cycle();
      check("t2_gnt", 128'(last_gnt), 128'(4'b0100));
      check("t2_rate_voltage", 128'(rate_voltage), 128'(16'hF800));
      cycle();
      check("t2_no_regrant", 128'(last_gnt), 128'(0));
      drain();
      check("t2_voltage_hold", 128'(rate_voltage), 128'(16'hF800));

      // 3: all requesters held high; pointer was left at 2
      for (int i = 0; i < NREQ; i++) set_v(i, RATE_W'(16'h1000 + 16'(i * 16'h0111)));
      gnt_log.delete();
      keep = '1; req = '1;
      for (int i = 0; i < 8; i++) cycle();
      keep = '0; req = '0;
      check("t3_count", 128'(gnt_log.size()), 128'(8));
      for (int k = 0; k < 8 && k < gnt_log.size(); k++)
         check("t3_order", 128'(gnt_log[k]), 128'((3 + k) % NREQ));
      drain();

      // 4: disable with grants in flight, drain to halt, then resume
      gnt_log.delete();
      req = '1;
      cycle();
      cycle();
      cfg_enable = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      check("t4_no_grant_disabled", 128'(gnt_log.size()), 128'(2));
      check("t4_halt_busy", 128'(busy), 128'(0));
      check("t4_rsp_drained", 128'(sb.size()), 128'(0));
      cfg_enable = 1'b1;
      for (int i = 0; i < 6 && gnt_log.size() < 3; i++) cycle();
      check("t4_resume_count", 128'(gnt_log.size()), 128'(3));
      if (gnt_log.size() >= 3) check("t4_resume_id", 128'(gnt_log[2]), 128'(1));
      cycle();
      check("t4_next_gnt", 128'(last_gnt), 128'(4'b0100));
      req = '0;
      drain();

      // 5: reset one cycle after two grants drops their responses
      gnt_log.delete();
      req = 4'b1001;
      cycle();
      cycle();
      check("t5_two_grants", 128'(gnt_log.size()), 128'(2));
      rst = 1'b1;
      sb.delete();
      cycle();
      rst = 1'b0;
      check("t5_busy_flush", 128'(busy), 128'(1));
      for (int i = 0; i < 3; i++) begin
         check("t5_flush_rate_rst_n", 128'(rate_rst_n), 128'(0));
         cycle();
      end
      check("t5_post_flush_rate_rst_n", 128'(rate_rst_n), 128'(1));
      set_v(2, 16'h1234);
      req = 4'b0100;
      cycle();
      check("t5_fresh_gnt", 128'(last_gnt), 128'(4'b0100));
      drain();

      // 6: nine more grants for ten since reset
      keep = '1; req = '1;
      for (int i = 0; i < 9; i++) cycle();
      keep = '0; req = '0;
      drain();
`ifdef HH_SCHED_PERF_EN
      check("t6_perf_grants", 128'(perf_grants), 128'(10));
      check("t6_perf_stalls", 128'(perf_stalls), 128'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
